reg_wr_scheduler: RTL and testbench
===================================

// Module: reg_wr_scheduler
// PURPOSE
//  Write-port scheduler for the 16x32 register bank.
//  - Shares the single write path (destination select + LDR_mux data) between NUM_REQ producers,
//    e.g. ALU result and load return, using round-robin arbitration.
//  - Keeps a pending-write scoreboard so issue logic can stall on source registers whose producer
//    has not yet written.
//  - Sits between the producers and reg_bank_toplevel; wr_en gates the bank's write decode.
// PARAMETERS
//  NUM_REQ  4   number of write requesters (2..8)
//  DATA_W   32  register data width
//  ADDR_W   4   register index width (2**ADDR_W registers)
// PORTS
//  clk          in   1                 rising-edge clock
//  rst          in   1                 synchronous reset, active-high
//  req_valid    in   NUM_REQ           requester i has a write pending
//  req_ready    out  NUM_REQ           requester i's write accepted this cycle (combinational)
//  req_dest     in   NUM_REQ*ADDR_W    dest index, requester i in bits [i*ADDR_W +: ADDR_W]
//  req_data     in   NUM_REQ*DATA_W    write data, requester i in bits [i*DATA_W +: DATA_W]
//  wr_stall     in   1                 bank cannot accept a write this cycle
//  wr_en        out  1                 registered write strobe to bank
//  destination  out  ADDR_W            registered write index to bank
//  ldr_data     out  DATA_W            registered write data to bank (LDR_mux)
//  pend_set     in   1                 issue logic claims a destination
//  pend_dest    in   ADDR_W            register being claimed
//  flush        in   1                 clear entire scoreboard
//  src_1_sel    in   ADDR_W            source 1 index to check
//  src_2_sel    in   ADDR_W            source 2 index to check
//  src_1_busy   out  1                 pend[src_1_sel] (combinational)
//  src_2_busy   out  1                 pend[src_2_sel] (combinational)
//  pend_vec     out  2**ADDR_W         scoreboard state
// BEHAVIOUR
//  Reset values: wr_en=0, destination=0, ldr_data=0, pend_vec=0, rr_ptr=0. req_ready=0 while rst=1.
//  Arbitration:
//  - rr_ptr (log2 NUM_REQ bits) is the highest-priority index.
//  - Search runs rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//  - The first i with req_valid[i]=1 gets req_ready[i]=1. At most one ready per cycle.
//  - wr_stall=1 forces all req_ready=0.
//  - No grant means req_ready=0 and rr_ptr holds.
//  Transfer: req_valid[i] & req_ready[i] at edge N:
//  - Edge N: rr_ptr <= (i+1) mod NUM_REQ.
//  - Edge N: destination <= req_dest[i], ldr_data <= req_data[i].
//  - wr_en=1 during cycle N+1. Latency is 1 cycle.
//  Idle cycles:
//  - wr_en=0 in any cycle that follows an edge with no transfer.
//  - destination and ldr_data hold their last values.
//  - Back-to-back transfers give continuous wr_en=1.
//  Requesters: must hold req_dest/req_data stable while valid and not ready. Ready does not depend on data.
//  Scoreboard pend[r], updated at each edge in this order:
//    1. flush=1 -> all bits cleared.
//    2. wr_en=1 (write being presented to bank) -> pend[destination] cleared.
//    3. pend_set=1 -> pend[pend_dest] set.
//  - Later steps win, so set+clear of the same index in one cycle leaves it set.
//  - flush+pend_set leaves only pend_dest set.
//  - A write to a non-pending register is legal and leaves its bit 0.
//  Hazards:
//  - src_1_busy/src_2_busy reflect the registered pend only. No bypass of the same-cycle write or set.
//  - Two requesters with the same dest in one cycle: only the granted one transfers; the other waits.
//  - Reset mid-transfer: the captured write is discarded (wr_en=0 next cycle), scoreboard cleared.
//  - Width rules: all indices are unsigned; rr_ptr wraps NUM_REQ-1 -> 0.
// TESTING
//  T1 reset: assert rst 2 cycles with all valids high -> req_ready=0, wr_en=0, pend_vec=0, rr_ptr=0.
//  T2 single write: req0 dest=5 data=32'hDEADBEEF -> ready0 same cycle;
//     next cycle wr_en=1, destination=5, ldr_data=DEADBEEF; wr_en=0 after.
//  T3 round-robin: all 4 valid continuously ->
//     grant order 0,1,2,3,0; wr_en high 5 consecutive cycles.
//  T4 stall: req1 valid, wr_stall=1 for 3 cycles -> ready1=0 throughout;
//     wr_stall drops -> ready1=1, write one cycle later.
//  T5 scoreboard: pend_set dest=7, then src_1_sel=7 -> src_1_busy=1;
//     req2 writes dest 7 -> busy drops the cycle after wr_en=1.
//     Same-cycle set+write of 7 -> busy stays 1.
//  T6 flush/reset mid-op: pend 3 and 9 set, req0 granted, then flush+rst ->
//     pend_vec=0, wr_en=0 next cycle, no write to bank.

Source files
------------

// File: rtl/reg_wr_scheduler.sv
// Write-port scheduler for the register bank: round-robin arbitration of
// NUM_REQ write producers onto one registered write path, plus a
// pending-write scoreboard that issue logic uses to detect source hazards.
//
// Handshake: requester i transfers on a rising edge where
// req_valid[i] & req_ready[i] are both 1. req_ready depends only on
// req_valid, rr_ptr, wr_stall and rst, never on req_dest/req_data. A
// requester keeps valid, dest and data stable until it sees ready.
module reg_wr_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_dest,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic                        wr_stall,
   output logic                        wr_en,
   output logic [ADDR_W-1:0]           destination,
   output logic [DATA_W-1:0]           ldr_data,
   input  logic                        pend_set,
   input  logic [ADDR_W-1:0]           pend_dest,
   input  logic                        flush,
   input  logic [ADDR_W-1:0]           src_1_sel,
   input  logic [ADDR_W-1:0]           src_2_sel,
   output logic                        src_1_busy,
   output logic                        src_2_busy,
   output logic [(2**ADDR_W)-1:0]      pend_vec
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int NUM_REGS = 2**ADDR_W;

   logic [PTR_W-1:0]    rr_ptr;
   logic [PTR_W-1:0]    grant_idx;
   logic                grant_found;
   logic                transfer;
   logic [PTR_W-1:0]    rr_ptr_next;
   logic [NUM_REGS-1:0] pend;
   logic [NUM_REGS-1:0] pend_next;

   // Round-robin search starting at rr_ptr; first valid requester wins.
   always_comb begin
      int unsigned idx;
      req_ready   = '0;
      grant_idx   = '0;
      grant_found = 1'b0;
      idx         = 0;
      if (!rst && !wr_stall) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
               grant_found    = 1'b1;
               grant_idx      = PTR_W'(idx);
               req_ready[idx] = 1'b1;
            end
         end
      end
   end

   assign transfer    = grant_found;
   assign rr_ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

   // Scoreboard update: flush, then clear the bit being written, then set;
   // the later step wins when two touch the same bit.
   always_comb begin
      pend_next = pend;
      if (flush)
         pend_next = '0;
      if (wr_en)
         pend_next[destination] = 1'b0;
      if (pend_set)
         pend_next[pend_dest] = 1'b1;
   end

   // Write path register, arbitration pointer and scoreboard state.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en       <= 1'b0;
         destination <= '0;
         ldr_data    <= '0;
         rr_ptr      <= '0;
         pend        <= '0;
      end else begin
         wr_en <= transfer;
         pend  <= pend_next;
         if (transfer) begin
            destination <= req_dest[grant_idx*ADDR_W +: ADDR_W];
            ldr_data    <= req_data[grant_idx*DATA_W +: DATA_W];
            rr_ptr      <= rr_ptr_next;
         end
      end
   end

   // Hazard lookups see only the registered scoreboard (no bypass).
   assign src_1_busy = pend[src_1_sel];
   assign src_2_busy = pend[src_2_sel];
   assign pend_vec   = pend;

endmodule

// File: tb/tb_reg_wr_scheduler.sv
// Bench for reg_wr_scheduler: a per-cycle vector table covering reset,
// single writes, round-robin order, stall and scoreboard updates, followed
// by a hand-written flush/reset-mid-transfer sequence.
module tb_reg_wr_scheduler;

   logic         clk;
   logic         rst;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [15:0]  req_dest;
   logic [127:0] req_data;
   logic         wr_stall;
   logic         wr_en;
   logic [3:0]   destination;
   logic [31:0]  ldr_data;
   logic         pend_set;
   logic [3:0]   pend_dest;
   logic         flush;
   logic [3:0]   src_1_sel;
   logic [3:0]   src_2_sel;
   logic         src_1_busy;
   logic         src_2_busy;
   logic [15:0]  pend_vec;

   int n_checks;
   int n_fail;

   reg_wr_scheduler #(.NUM_REQ(4), .DATA_W(32), .ADDR_W(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_dest(req_dest), .req_data(req_data),
      .wr_stall(wr_stall),
      .wr_en(wr_en), .destination(destination), .ldr_data(ldr_data),
      .pend_set(pend_set), .pend_dest(pend_dest), .flush(flush),
      .src_1_sel(src_1_sel), .src_2_sel(src_2_sel),
      .src_1_busy(src_1_busy), .src_2_busy(src_2_busy),
      .pend_vec(pend_vec)
   );

   // Clock: 10 time-unit period, rising edges at 5, 15, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic [3:0]  v;
      logic        st;
      logic        ps;
      logic [3:0]  pd;
      logic        fl;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic [3:0]  e_ready;
      logic        e_wr;
      logic [3:0]  e_dest;
      logic [31:0] e_data;
      logic [15:0] e_pend;
      logic        e_b1;
      logic        e_b2;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic [3:0] v, logic st, logic ps, logic [3:0] pd,
                               logic fl, logic [3:0] s1, logic [3:0] s2,
                               logic [3:0] er, logic ew, logic [3:0] ed, logic [31:0] edata,
                               logic [15:0] ep, logic eb1, logic eb2);
      vec_t t;
      t.r = r; t.v = v; t.st = st; t.ps = ps; t.pd = pd; t.fl = fl; t.s1 = s1; t.s2 = s2;
      t.e_ready = er; t.e_wr = ew; t.e_dest = ed; t.e_data = edata;
      t.e_pend = ep; t.e_b1 = eb1; t.e_b2 = eb2;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] v, input logic st, input logic ps,
                        input logic [3:0] pd, input logic fl, input logic [3:0] s1,
                        input logic [3:0] s2);
      rst = r; req_valid = v; wr_stall = st; pend_set = ps; pend_dest = pd;
      flush = fl; src_1_sel = s1; src_2_sel = s2;
   endtask

   task automatic check_all(input string tag, input vec_t t);
      chk({tag, ".ready"}, {28'd0, req_ready}, {28'd0, t.e_ready});
      chk({tag, ".wr_en"}, {31'd0, wr_en}, {31'd0, t.e_wr});
      chk({tag, ".destination"}, {28'd0, destination}, {28'd0, t.e_dest});
      chk({tag, ".ldr_data"}, ldr_data, t.e_data);
      chk({tag, ".pend_vec"}, {16'd0, pend_vec}, {16'd0, t.e_pend});
      chk({tag, ".src_1_busy"}, {31'd0, src_1_busy}, {31'd0, t.e_b1});
      chk({tag, ".src_2_busy"}, {31'd0, src_2_busy}, {31'd0, t.e_b2});
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      // Fixed requester payloads: dest 5,6,7,9 and distinct data words.
      req_dest = {4'd9, 4'd7, 4'd6, 4'd5};
      req_data = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
      drive(1'b1, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
      @(posedge clk);

      //          r  v    st ps pd  fl s1 s2  | rdy wr dst data          pend      b1 b2
      // reset held with all requesters valid
      vecs.push_back(mk(1, 4'hF, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h0, 16'h0, 0, 0));
      vecs.push_back(mk(1, 4'hF, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 32'h0, 16'h0, 0, 0));
      // single write from req0, then idle
      vecs.push_back(mk(0, 4'h1, 0, 0, 0, 0, 0, 0, 4'h1, 0, 0, 32'h0, 16'h0, 0, 0));
      vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 5, 32'hDEADBEEF, 16'h0, 0, 0));
      vecs.push_back(mk(1, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 5, 32'hDEADBEEF, 16'h0, 0, 0));
      // round robin with all valid: grants 0,1,2,3,0 and five wr_en cycles
      vecs.push_back(mk(0, 4'hF, 0, 0, 0, 0, 0, 0, 4'h1, 0, 0, 32'h0, 16'h0, 0, 0));
      vecs.push_back(mk(0, 4'hF, 0, 0, 0, 0, 0, 0, 4'h2, 1, 5, 32'hDEADBEEF, 16'h0, 0, 0));
      vecs.push_back(mk(0, 4'hF, 0, 0, 0, 0, 0, 0, 4'h4, 1, 6, 32'h11111111, 16'h0, 0, 0));
      vecs.push_back(mk(0, 4'hF, 0, 0, 0, 0, 0, 0, 4'h8, 1, 7, 32'h22222222, 16'h0, 0, 0));
      vecs.push_back(mk(0, 4'hF, 0, 0, 0, 0, 0, 0, 4'h1, 1, 9, 32'h33333333, 16'h0, 0, 0));
      vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 5, 32'hDEADBEEF, 16'h0, 0, 0));
      // stall three cycles on req1, then released
      vecs.push_back(mk(0, 4'h2, 1, 0, 0, 0, 0, 0, 4'h0, 0, 5, 32'hDEADBEEF, 16'h0, 0, 0));
      vecs.push_back(mk(0, 4'h2, 1, 0, 0, 0, 0, 0, 4'h0, 0, 5, 32'hDEADBEEF, 16'h0, 0, 0));
      vecs.push_back(mk(0, 4'h2, 1, 0, 0, 0, 0, 0, 4'h0, 0, 5, 32'hDEADBEEF, 16'h0, 0, 0));
      vecs.push_back(mk(0, 4'h2, 0, 0, 0, 0, 0, 0, 4'h2, 0, 5, 32'hDEADBEEF, 16'h0, 0, 0));
      vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 6, 32'h11111111, 16'h0, 0, 0));
      // scoreboard: claim 7 (no bypass), req2 writes 7, busy drops after wr_en
      vecs.push_back(mk(0, 4'h0, 0, 1, 7, 0, 7, 5, 4'h0, 0, 6, 32'h11111111, 16'h0000, 0, 0));
      vecs.push_back(mk(0, 4'h4, 0, 0, 0, 0, 7, 5, 4'h4, 0, 6, 32'h11111111, 16'h0080, 1, 0));
      vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0, 7, 5, 4'h0, 1, 7, 32'h22222222, 16'h0080, 1, 0));
      // set coinciding with a write of 7: set wins
      vecs.push_back(mk(0, 4'h4, 0, 0, 0, 0, 7, 5, 4'h4, 0, 7, 32'h22222222, 16'h0000, 0, 0));
      vecs.push_back(mk(0, 4'h0, 0, 1, 7, 0, 7, 5, 4'h0, 1, 7, 32'h22222222, 16'h0000, 0, 0));
      vecs.push_back(mk(0, 4'h4, 0, 0, 0, 0, 7, 5, 4'h4, 0, 7, 32'h22222222, 16'h0080, 1, 0));
      vecs.push_back(mk(0, 4'h0, 0, 1, 7, 0, 7, 5, 4'h0, 1, 7, 32'h22222222, 16'h0080, 1, 0));
      // flush together with a claim of 3 leaves only bit 3
      vecs.push_back(mk(0, 4'h0, 0, 1, 3, 1, 7, 5, 4'h0, 0, 7, 32'h22222222, 16'h0080, 1, 0));
      vecs.push_back(mk(0, 4'h0, 0, 0, 0, 0, 7, 3, 4'h0, 0, 7, 32'h22222222, 16'h0008, 0, 1));

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].r, vecs[i].v, vecs[i].st, vecs[i].ps, vecs[i].pd, vecs[i].fl,
               vecs[i].s1, vecs[i].s2);
         #2;
         check_all($sformatf("vec%0d", i), vecs[i]);
      end

      // Pending 3 and 9, req0 granted, then flush+rst while its write is out.
      @(negedge clk);
      drive(1'b0, 4'h0, 1'b0, 1'b1, 4'd9, 1'b0, 4'd3, 4'd9);
      #2;
      chk("t6.pend_pre", {16'd0, pend_vec}, 32'h0008);
      @(negedge clk);
      drive(1'b0, 4'h1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 4'd9);
      #2;
      chk("t6.pend_3_9", {16'd0, pend_vec}, 32'h0208);
      chk("t6.busy1", {31'd0, src_1_busy}, 32'd1);
      chk("t6.busy2", {31'd0, src_2_busy}, 32'd1);
      chk("t6.ready0", {28'd0, req_ready}, 32'h1);
      @(negedge clk);
      drive(1'b1, 4'h1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 4'd9);
      #2;
      chk("t6.ready_in_rst", {28'd0, req_ready}, 32'h0);
      chk("t6.wr_en_before_rst", {31'd0, wr_en}, 32'd1);
      @(negedge clk);
      drive(1'b1, 4'h1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 4'd9);
      #2;
      chk("t6.wr_en_after_rst", {31'd0, wr_en}, 32'd0);
      chk("t6.pend_cleared", {16'd0, pend_vec}, 32'h0);
      chk("t6.dest_reset", {28'd0, destination}, 32'h0);
      chk("t6.data_reset", ldr_data, 32'h0);
      chk("t6.busy_cleared", {31'd0, src_1_busy}, 32'd0);
      // rr_ptr must be back at 0: with 0 and 1 valid, 0 wins.
      @(negedge clk);
      drive(1'b0, 4'h3, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
      #2;
      chk("t6.rr_reset", {28'd0, req_ready}, 32'h1);
      chk("t6.no_write", {31'd0, wr_en}, 32'd0);
      @(negedge clk);
      drive(1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
      #2;
      chk("t6.post_wr_en", {31'd0, wr_en}, 32'd1);
      chk("t6.post_dest", {28'd0, destination}, 32'd5);
      chk("t6.post_data", ldr_data, 32'hDEADBEEF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
